// File: rtl/s2mm_pkg.sv
// Shared types and the configuration legality check for the ping-pong stream writer.
package s2mm_pkg;

  typedef enum logic [1:0] {
    BUF_FREE,
    BUF_FILLING,
    BUF_FULL,
    BUF_BUSY
  } buf_state_t;

  typedef enum logic {
    MODE_COL,
    MODE_ROW
  } mode_t;

  // True when an R x C batch fits the banked buffer in the requested mode.
  // Only evaluated once per batch, so the multiply stays off the per-beat path.
  function automatic logic cfg_legal(input logic [31:0] rows, input logic [31:0] cols,
                                     input logic mode, input int unsigned n_bank,
                                     input int unsigned addr_w);
    longint unsigned words;
    longint unsigned limit;
    logic            ok;
    words = 64'(0);
    limit = 64'(1) << addr_w;
    if (rows == 32'd0 || cols == 32'd0) begin
      ok = 1'b0;
    end else if (mode == 1'b0) begin
      ok    = (cols % n_bank) == 32'd0;
      words = 64'(rows) * 64'(cols / n_bank);
    end else begin
      ok    = (rows % n_bank) == 32'd0;
      words = 64'(rows / n_bank) * 64'(cols);
    end
    return ok && (words <= limit);
  endfunction

endpackage

// File: rtl/s2mm_addr_gen.sv
// Row/column counters with incremental bank/address generation for one batch.
module s2mm_addr_gen
  import s2mm_pkg::*;
#(
  parameter int unsigned N_BANK       = 4,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned MATRIXSIZE_W = 16,
  localparam int unsigned BANK_W      = $clog2(N_BANK)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    beat_i,
  input  logic                    clear_i,
  input  logic [MATRIXSIZE_W-1:0] rows_i,
  input  logic [MATRIXSIZE_W-1:0] cols_i,
  input  mode_t                   mode_i,
  output logic [BANK_W-1:0]       bank_o,
  output logic [ADDR_W-1:0]       addr_o,
  output logic                    last_expected_o
);

  logic [MATRIXSIZE_W-1:0] i_q, i_d;
  logic [MATRIXSIZE_W-1:0] j_q, j_d;
  // Address of element (i, 0) in the current bank row; advanced on column wrap.
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [ADDR_W-1:0]       base_inc;
  logic                    j_wrap;
  logic                    row_group_end;

  assign j_wrap        = (j_q == cols_i - MATRIXSIZE_W'(1));
  assign row_group_end = (i_q[BANK_W-1:0] == {BANK_W{1'b1}});

  // Bank/address of the current beat and the base step for the next row.
  always_comb begin
    bank_o   = '0;
    addr_o   = '0;
    base_inc = '0;
    if (mode_i == MODE_COL) begin
      bank_o   = j_q[BANK_W-1:0];
      addr_o   = base_q + ADDR_W'(j_q >> BANK_W);
      base_inc = ADDR_W'(cols_i >> BANK_W);
    end else begin
      bank_o   = i_q[BANK_W-1:0];
      addr_o   = base_q + ADDR_W'(j_q);
      // Every bank has received one full row: move to the next bank row.
      base_inc = row_group_end ? ADDR_W'(cols_i) : '0;
    end
  end

  assign last_expected_o = (rows_i != '0) && (cols_i != '0) && j_wrap &&
                           (i_q == rows_i - MATRIXSIZE_W'(1));

  // Counter advance; clear wins so the closing beat restarts the next batch at (0, 0).
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    base_d = base_q;
    if (clear_i) begin
      i_d    = '0;
      j_d    = '0;
      base_d = '0;
    end else if (beat_i) begin
      if (j_wrap) begin
        j_d    = '0;
        i_d    = i_q + MATRIXSIZE_W'(1);
        base_d = base_q + base_inc;
      end else begin
        j_d = j_q + MATRIXSIZE_W'(1);
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q    <= '0;
      j_q    <= '0;
      base_q <= '0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      base_q <= base_d;
    end
  end

endmodule

// File: rtl/s2mm_pingpong_writer.sv
// AXI-Stream to banked memory writer with two ping-pong buffer halves.
module s2mm_pingpong_writer
  import s2mm_pkg::*;
#(
  parameter int unsigned D_W          = 8,
  parameter int unsigned N_BANK       = 4,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned MATRIXSIZE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [D_W-1:0]          s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [MATRIXSIZE_W-1:0] cfg_rows,
  input  logic [MATRIXSIZE_W-1:0] cfg_cols,
  input  logic                    cfg_mode,
  output logic [N_BANK-1:0]       wr_en,
  output logic [ADDR_W:0]         wr_addr,
  output logic [D_W-1:0]          wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    rd_buf,
  input  logic                    rd_done,
  output logic                    len_err,
  output logic                    cfg_err,
  input  logic                    err_clr
);

  localparam int unsigned BANK_W = $clog2(N_BANK);

  buf_state_t              buf_q [2];
  buf_state_t              buf_d [2];
  logic                    wr_sel_q, wr_sel_d;
  logic                    rd_buf_q, rd_buf_d;
  logic                    init_q;
  logic [MATRIXSIZE_W-1:0] rows_q, cols_q;
  mode_t                   mode_q;
  logic                    legal_q;
  logic [N_BANK-1:0]       wr_en_q;
  logic [ADDR_W:0]         wr_addr_q;
  logic [D_W-1:0]          wr_data_q;
  logic                    len_err_q, len_err_d;
  logic                    cfg_err_q, cfg_err_d;

  logic                    accept, first, close, release_rd;
  logic [MATRIXSIZE_W-1:0] rows_e, cols_e;
  mode_t                   mode_e;
  logic                    legal_e;
  logic [BANK_W-1:0]       bank;
  logic [ADDR_W-1:0]       addr;
  logic                    last_exp;

  // init_q keeps tready low until the first edge after reset release.
  assign s_axis_tready = init_q &&
                         (buf_q[wr_sel_q] == BUF_FREE || buf_q[wr_sel_q] == BUF_FILLING);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign first         = accept && (buf_q[wr_sel_q] == BUF_FREE);

  // The first beat of a batch uses the live cfg; later beats use the latched copy.
  assign rows_e  = first ? cfg_rows : rows_q;
  assign cols_e  = first ? cfg_cols : cols_q;
  assign mode_e  = first ? mode_t'(cfg_mode) : mode_q;
  assign legal_e = first ? cfg_legal(32'(cfg_rows), 32'(cfg_cols), cfg_mode, N_BANK, ADDR_W)
                         : legal_q;

  assign close      = accept && (s_axis_tlast || last_exp);
  assign release_rd = rd_done && (buf_q[rd_buf_q] == BUF_BUSY);

  s2mm_addr_gen #(
    .N_BANK       (N_BANK),
    .ADDR_W       (ADDR_W),
    .MATRIXSIZE_W (MATRIXSIZE_W)
  ) u_addr_gen (
    .clk             (clk),
    .rst_n           (rst_n),
    .beat_i          (accept),
    .clear_i         (close),
    .rows_i          (rows_e),
    .cols_i          (cols_e),
    .mode_i          (mode_e),
    .bank_o          (bank),
    .addr_o          (addr),
    .last_expected_o (last_exp)
  );

  // Buffer FSMs: the write side only moves FREE/FILLING, the read side only FULL/BUSY,
  // so both sides can act on the two buffers in the same cycle without conflict.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      buf_d[b] = buf_q[b];
      if (accept && wr_sel_q == 1'(b)) begin
        if (close) buf_d[b] = legal_e ? BUF_FULL : BUF_FREE;
        else       buf_d[b] = BUF_FILLING;
      end
      if (rd_buf_q == 1'(b)) begin
        if (buf_q[b] == BUF_FULL && rd_ready)     buf_d[b] = BUF_BUSY;
        else if (buf_q[b] == BUF_BUSY && rd_done) buf_d[b] = BUF_FREE;
      end
    end
    wr_sel_d = wr_sel_q ^ close;
    rd_buf_d = rd_buf_q ^ release_rd;
  end

  // Sticky errors; a same-cycle clear wins over a new error.
  always_comb begin
    len_err_d = len_err_q | (close && (s_axis_tlast != last_exp));
    cfg_err_d = cfg_err_q | (first && !legal_e);
    if (err_clr) begin
      len_err_d = 1'b0;
      cfg_err_d = 1'b0;
    end
  end

  // Buffer/handshake state and error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q[0]  <= BUF_FREE;
      buf_q[1]  <= BUF_FREE;
      wr_sel_q  <= 1'b0;
      rd_buf_q  <= 1'b0;
      init_q    <= 1'b0;
      len_err_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      wr_sel_q  <= wr_sel_d;
      rd_buf_q  <= rd_buf_d;
      init_q    <= 1'b1;
      len_err_q <= len_err_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Batch configuration latch on the first accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q  <= '0;
      cols_q  <= '0;
      mode_q  <= MODE_COL;
      legal_q <= 1'b0;
    end else if (first) begin
      rows_q  <= cfg_rows;
      cols_q  <= cfg_cols;
      mode_q  <= mode_t'(cfg_mode);
      legal_q <= legal_e;
    end
  end

  // Write-port register: one-cycle strobe per accepted beat of a legal batch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= (accept && legal_e) ? (N_BANK'(1) << bank) : '0;
      if (accept) begin
        wr_addr_q <= {wr_sel_q, addr};
        wr_data_q <= s_axis_tdata;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_valid = (buf_q[rd_buf_q] == BUF_FULL);
  assign rd_buf   = rd_buf_q;
  assign len_err  = len_err_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_s2mm_pingpong_writer.sv
// Scoreboard bench for the ping-pong stream writer (N_BANK=4, ADDR_W=12, D_W=8).
module tb_s2mm_pingpong_writer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [15:0] cfg_rows;
  logic [15:0] cfg_cols;
  logic        cfg_mode;
  logic [3:0]  wr_en;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_buf;
  logic        rd_done;
  logic        len_err;
  logic        cfg_err;
  logic        err_clr;

  typedef struct packed {
    logic [3:0]  en;
    logic [12:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   exp_sel;
  int   pos;

  s2mm_pingpong_writer #(
    .D_W          (8),
    .N_BANK       (4),
    .ADDR_W       (12),
    .MATRIXSIZE_W (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .cfg_rows      (cfg_rows),
    .cfg_cols      (cfg_cols),
    .cfg_mode      (cfg_mode),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_buf        (rd_buf),
    .rd_done       (rd_done),
    .len_err       (len_err),
    .cfg_err       (cfg_err),
    .err_clr       (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_legal(input int r, input int c, input int m);
    if (r == 0 || c == 0) return 1'b0;
    if (m == 0) return (c % 4 == 0) && (r * (c / 4) <= 4096);
    return (r % 4 == 0) && ((r / 4) * c <= 4096);
  endfunction

  // Every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && wr_en != 4'd0) begin
      if (sb.size() == 0) begin
        check_eq("wr_unexpected", 32'(wr_en), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("wr_en", 32'(wr_en), 32'(mon_e.en));
        check_eq("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        check_eq("wr_data", 32'(wr_data), 32'(mon_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = 8'd0;
    rd_ready      = 1'b0;
    rd_done       = 1'b0;
    err_clr       = 1'b0;
    sb.delete();
    exp_sel = 1'b0;
    pos     = 0;
    #1;
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_tready", 32'(s_axis_tready), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_errs", 32'({len_err, cfg_err, rd_buf}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("tready_before_edge", 32'(s_axis_tready), 32'd0);
    tick();
    check_eq("tready_after_edge", 32'(s_axis_tready), 32'd1);
  endtask

  // Drive one beat, wait (bounded) for acceptance and record the expected write.
  task automatic send_beat(input int r, input int c, input int m, input bit last, input bit done);
    int          waited;
    int          i, j, bank, a;
    logic [7:0]  d;
    exp_t        e;
    d             = 8'($urandom_range(0, 255));
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    rd_done       = done;
    waited        = 0;
    @(negedge clk);
    while (!s_axis_tready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!s_axis_tready) begin
      check_eq("tready_timeout", 32'd0, 32'd1);
      s_axis_tvalid = 1'b0;
      rd_done       = 1'b0;
      return;
    end
    i = pos / c;
    j = pos % c;
    if (model_legal(r, c, m)) begin
      if (m == 0) begin
        bank = j % 4;
        a    = i * (c / 4) + j / 4;
      end else begin
        bank = i % 4;
        a    = (i / 4) * c + j;
      end
      e.en   = 4'(1 << bank);
      e.addr = {exp_sel, 12'(a)};
      e.data = d;
      sb.push_back(e);
    end
    if (last || pos == r * c - 1) begin
      exp_sel = ~exp_sel;
      pos     = 0;
    end else begin
      pos++;
    end
    tick();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    rd_done       = 1'b0;
  endtask

  task automatic send_batch(input int r, input int c, input int m, input int n,
                            input int last_idx, input int done_idx, input bit scramble);
    cfg_rows = 16'(r);
    cfg_cols = 16'(c);
    cfg_mode = m[0];
    for (int k = 0; k < n; k++) begin
      send_beat(r, c, m, k == last_idx, k == done_idx);
      if (scramble && k == 0) begin
        cfg_rows = 16'd7;
        cfg_cols = 16'd5;
        cfg_mode = ~m[0];
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    cfg_rows = 16'd0;
    cfg_cols = 16'd0;
    cfg_mode = 1'b0;

    // Column banking, cfg inputs changed after the first beat.
    do_reset();
    send_batch(2, 8, 0, 16, 15, -1, 1'b1);
    tick();
    check_eq("s1_rd_valid", 32'(rd_valid), 32'd1);
    check_eq("s1_len_err", 32'(len_err), 32'd0);
    check_eq("s1_cfg_err", 32'(cfg_err), 32'd0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check_eq("s1_rd_valid_taken", 32'(rd_valid), 32'd0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check_eq("s1_rd_buf_toggle", 32'(rd_buf), 32'd1);

    // Row banking, two batches with compute holding off.
    do_reset();
    send_batch(4, 3, 1, 12, 11, -1, 1'b0);
    send_batch(4, 3, 1, 12, 11, -1, 1'b0);
    tick();
    check_eq("s2_tready_both_full", 32'(s_axis_tready), 32'd0);
    check_eq("s2_rd_buf", 32'(rd_buf), 32'd0);
    check_eq("s2_rd_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check_eq("s2_tready_busy", 32'(s_axis_tready), 32'd0);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check_eq("s2_tready_freed", 32'(s_axis_tready), 32'd1);
    check_eq("s2_rd_buf_next", 32'(rd_buf), 32'd1);
    check_eq("s2_rd_valid_next", 32'(rd_valid), 32'd1);

    // rd_done of buffer 1 on the same edge as tlast into buffer 0.
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    send_batch(2, 8, 0, 16, 15, 15, 1'b0);
    check_eq("s5_tready", 32'(s_axis_tready), 32'd1);
    check_eq("s5_rd_buf", 32'(rd_buf), 32'd0);
    check_eq("s5_rd_valid", 32'(rd_valid), 32'd1);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check_eq("s5_stray_done_rd_buf", 32'(rd_buf), 32'd0);
    check_eq("s5_stray_done_rd_valid", 32'(rd_valid), 32'd1);

    // Early tlast.
    do_reset();
    send_batch(2, 8, 0, 10, 9, -1, 1'b0);
    tick();
    check_eq("s3_len_err", 32'(len_err), 32'd1);
    check_eq("s3_rd_valid", 32'(rd_valid), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("s3_len_err_clr", 32'(len_err), 32'd0);

    // Illegal column count: no writes, next batch lands in buffer 1.
    do_reset();
    send_batch(2, 6, 0, 12, 11, -1, 1'b0);
    tick();
    check_eq("s4_cfg_err", 32'(cfg_err), 32'd1);
    check_eq("s4_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("s4_len_err", 32'(len_err), 32'd0);
    check_eq("s4_tready", 32'(s_axis_tready), 32'd1);
    send_batch(4, 1, 1, 4, 3, -1, 1'b0);
    tick();
    check_eq("s4_cfg_err_sticky", 32'(cfg_err), 32'd1);

    // Reset in the middle of a batch, then a fresh batch from address {0,0}.
    do_reset();
    send_batch(2, 8, 0, 6, -1, -1, 1'b0);
    do_reset();
    send_batch(2, 8, 0, 16, 15, -1, 1'b0);
    tick();
    check_eq("s6_rd_valid", 32'(rd_valid), 32'd1);

    repeat (3) tick();
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/s2mm_pingpong_writer.md
Name: s2mm_pingpong_writer

Overview:
Successor to the single-buffer AXI-Stream-to-bank writer. It accepts a row-major matrix on an AXI-Stream slave and scatters the elements across N_BANK external write ports. The banking mode (by column or by row) is selected per batch at run time. It double-buffers with two address halves, so the next operand batch streams in while the systolic array reads the previous one. It also checks batch length against tlast and flags configuration errors.

Parameters:
D_W, 8, element width in bits
N_BANK, 4, number of memory banks (power of two)
ADDR_W, 12, per-buffer bank address width; each bank holds 2*2^ADDR_W words
MATRIXSIZE_W, 16, width of dimension inputs

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_tdata  in  D_W  element
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat ready
s_axis_tlast  in  1  last beat of batch
cfg_rows  in  MATRIXSIZE_W  rows R
cfg_cols  in  MATRIXSIZE_W  columns C
cfg_mode  in  1  0 = bank by column, 1 = bank by row
wr_en  out  N_BANK  one-hot bank write strobe
wr_addr  out  ADDR_W+1  {buffer select, address}
wr_data  out  D_W  write data
rd_valid  out  1  a FULL buffer is available
rd_ready  in  1  compute takes the buffer
rd_buf  out  1  buffer index offered or owned by compute
rd_done  in  1  pulse: compute has released the owned buffer
len_err  out  1  sticky: tlast and expected count disagreed
cfg_err  out  1  sticky: illegal configuration latched
err_clr  in  1  clears both sticky errors

Behaviour:
- Reset (async, rst_n=0): both buffers FREE; wr_sel=0, rd_buf=0; all outputs 0. s_axis_tready rises on the first clk edge after rst_n deasserts.
- Buffer states: FREE -> FILLING (first accepted beat) -> FULL (batch closes, cfg legal) -> BUSY (rd_valid&&rd_ready) -> FREE (rd_done).
  - A FILLING batch with illegal cfg closes straight to FREE.
- s_axis_tready = 1 iff buffer[wr_sel] is FREE or FILLING. A beat is accepted when tvalid&&tready.
- Config latch: cfg_rows, cfg_cols, cfg_mode are latched on the first accepted beat of a batch and ignored for the rest of the batch.
- Legality:
  - Mode 0: C%N_BANK==0 and R*(C/N_BANK) <= 2^ADDR_W.
  - Mode 1: R%N_BANK==0 and (R/N_BANK)*C <= 2^ADDR_W.
  - R=0 or C=0 is illegal.
- Illegal cfg: cfg_err set in the cycle after the latch; all beats of the batch are accepted but wr_en stays 0.
- Element (i,j), mode 0: bank j%N_BANK, addr i*(C/N_BANK) + j/N_BANK.
- Element (i,j), mode 1: bank i%N_BANK, addr (i/N_BANK)*C + j.
- Counters: j increments per beat and wraps at C-1; i increments on each j wrap. Addresses are computed incrementally, with no multipliers in the per-beat path.
- Write latency: beat accepted at edge t -> wr_en/wr_addr/wr_data valid during the cycle after edge t, for exactly one cycle. wr_addr MSB = wr_sel of that batch.
- Batch close: the batch closes on the accepted beat where tlast=1 OR count==R*C-1, whichever comes first. len_err is set (next cycle) if the two do not coincide.
  - On close, wr_sel toggles and the counters clear.
  - Beats after an early close belong to the next batch.
- Read side:
  - rd_valid = (buffer[rd_buf]==FULL).
  - On rd_valid&&rd_ready, buffer[rd_buf] becomes BUSY; rd_valid drops next cycle.
  - On rd_done with buffer[rd_buf] BUSY: that buffer becomes FREE and rd_buf toggles. rd_done in any other state is ignored.
- Simultaneous events: close of one buffer and rd_done of the other in the same cycle both take effect. A FREE buffer made available by rd_done is writable in the next cycle (tready rises then).
- err_clr takes priority over a same-cycle error set.

Decomposition:
- s2mm_pkg holds:
  - buf_state_t enum {BUF_FREE, BUF_FILLING, BUF_FULL, BUF_BUSY}
  - mode_t enum {MODE_COL, MODE_ROW}
  - function cfg_legal(R, C, mode, N_BANK, ADDR_W)
- One sub-module, s2mm_addr_gen, contains the i/j counters, incremental bank/address generation, and the expected-count compare. Its inputs are beat, clear, and the latched cfg. Its outputs are bank, addr, and last_expected.
- Top level holds the two buffer FSMs, the tready/rd handshake, the write-output register, and the errors.

Test Plan:
- N_BANK=4, mode 0, R=2, C=8, beats 0..15 with tlast on beat 15:
  - beat 5 -> wr_en=4'b0010, wr_addr={0,1}; beat 15 -> wr_en=4'b1000, addr {0,3}.
  - rd_valid=1 two cycles after beat 15; len_err=0.
- Mode 1, R=4, C=3, 12 beats:
  - beat 7 (i=2, j=1) -> wr_en=4'b0100, addr {0,1}.
  - Second batch with rd_ready held low: writes go to {1,*}. After it completes, tready=0 until rd_ready and rd_done return buffer 0.
- Mode 0, R=2, C=8, tlast on beat 9: batch closes, len_err=1, FULL buffer offered. err_clr -> len_err=0 next cycle.
- Mode 0 with C=6 (not a multiple of 4): cfg_err=1; 12 beats accepted, wr_en never asserts, rd_valid stays 0, wr_sel toggles.
- rd_done in the same cycle as the tlast of the other buffer: both transitions occur and tready stays high. rd_done pulsed while no buffer is BUSY: no state change.
- rst_n low mid-batch (beat 6 of 16): outputs 0 immediately. After release, a fresh batch writes from addr {0,0}.
